chip8_program_loader: RTL and testbench

- Writer-side counterpart of the 4 KB CHIP-8 program memory.
- Accepts a length-prefixed byte stream over a valid/ready handshake, typically from a UART receiver or host bridge.
- Writes the payload into memory starting at the program base address (0x200) through a registered write port.
- Holds the CPU in reset while loading and reports completion or error.

---
 rtl/chip8_program_loader_if.sv | 23 ++
 rtl/chip8_program_loader.sv | 130 +++++++++++++
 tb/tb_chip8_program_loader.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/chip8_program_loader_if.sv
`timescale 1ns/1ps
// Byte stream in (valid/ready) and registered memory write port out of the CHIP-8 program loader.
// master = stream source / memory sink side, slave = loader side.
interface chip8_program_loader_if #(
    parameter int ADDR_W = 12
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/chip8_program_loader.sv
`timescale 1ns/1ps
// Loads a length-prefixed byte stream into CHIP-8 memory from LOAD_BASE; optional LOADER_CHECKSUM_EN adds a trailing sum byte.
// Latency: byte handshake to mem_we is 1 cycle, one byte per cycle sustained.
// Backpressure: in_ready only in header/payload/checksum states and never in a start cycle.
module chip8_program_loader #(
    parameter int              ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] LOAD_BASE = 12'h200,
    parameter int              MEM_BYTES = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    chip8_program_loader_if.slave  bus,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [12:0]            byte_count
);

    localparam logic [15:0] MAX_LEN = 16'(MEM_BYTES - int'(LOAD_BASE));

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR
    } state_t;
    localparam state_t AFTER_PAYLOAD = CSUM;
`else
    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA, DONE, ERROR
    } state_t;
    localparam state_t AFTER_PAYLOAD = DONE;
`endif

    state_t      state_q, state_d;
    logic [15:0] len_q;
    logic [15:0] len_full;
    logic        hs;
    logic        last_byte;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  sum_q;
`endif

    assign hs = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bus.in_ready = 1'b0;
        busy         = 1'b0;
        done         = (state_q == DONE);
        error        = (state_q == ERROR);
        len_full     = {len_q[15:8], bus.in_data};
        last_byte    = (({3'b000, byte_count} + 16'd1) == len_q);

        case (state_q)
            LEN_HI, LEN_LO, DATA: busy = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            CSUM:                 busy = 1'b1;
`endif
            default:              busy = 1'b0;
        endcase
        bus.in_ready = busy && !start;

        if (start) begin
            state_d = LEN_HI;
        end else begin
            case (state_q)
                LEN_HI: if (hs) state_d = LEN_LO;
                LEN_LO: begin
                    // Oversize lengths are rejected here so the write address can never pass the top of memory.
                    if (hs) begin
                        if (len_full == 16'd0)       state_d = AFTER_PAYLOAD;
                        else if (len_full > MAX_LEN) state_d = ERROR;
                        else                         state_d = DATA;
                    end
                end
                DATA: if (hs && last_byte) state_d = AFTER_PAYLOAD;
`ifdef LOADER_CHECKSUM_EN
                CSUM: if (hs) state_d = (bus.in_data == sum_q) ? DONE : ERROR;
`endif
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q         <= 16'd0;
            byte_count    <= 13'd0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= LOAD_BASE;
            bus.mem_wdata <= 8'd0;
`ifdef LOADER_CHECKSUM_EN
            sum_q         <= 8'd0;
`endif
        end else begin
            bus.mem_we <= 1'b0;
            if (start) begin
                len_q      <= 16'd0;
                byte_count <= 13'd0;
`ifdef LOADER_CHECKSUM_EN
                sum_q      <= 8'd0;
`endif
            end else if (hs) begin
                case (state_q)
                    LEN_HI: len_q[15:8] <= bus.in_data;
                    LEN_LO: len_q[7:0]  <= bus.in_data;
                    DATA: begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= LOAD_BASE + byte_count[ADDR_W-1:0];
                        bus.mem_wdata <= bus.in_data;
                        byte_count    <= byte_count + 13'd1;
`ifdef LOADER_CHECKSUM_EN
                        sum_q         <= sum_q + bus.in_data;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_chip8_program_loader.sv
`timescale 1ns/1ps
// Bench for chip8_program_loader: vector table of load scenarios, write scoreboard with latency check,
// plus restart-mid-load and async-reset sequences.
module tb_chip8_program_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, error;
    logic [12:0] byte_count;

    chip8_program_loader_if #(.ADDR_W(12)) bus ();

    chip8_program_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;
    wr_t exp_q[$];

    int         widx;
    logic [7:0] sum;

    typedef struct {
        int         len;
        logic [7:0] seed;
        logic [7:0] step;
        bit         toggle;
        bit         bad_csum;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every write must match the oldest accepted payload byte, in the cycle right after its handshake.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && bus.mem_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (bus.mem_addr !== e.addr || bus.mem_wdata !== e.data || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL write: got addr=%0h data=%0h cyc=%0d expected addr=%0h data=%0h cyc=%0d",
                             bus.mem_addr, bus.mem_wdata, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"},   32'(bus.in_ready), 32'h0);
        chk({tag, "_mem_we"},     32'(bus.mem_we), 32'h0);
        chk({tag, "_busy"},       32'(busy), 32'h0);
        chk({tag, "_done"},       32'(done), 32'h0);
        chk({tag, "_error"},      32'(error), 32'h0);
        chk({tag, "_mem_addr"},   32'(bus.mem_addr), 32'h200);
        chk({tag, "_mem_wdata"},  32'(bus.mem_wdata), 32'h0);
        chk({tag, "_byte_count"}, 32'(byte_count), 32'h0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit toggle, output bit ok, output int hcyc);
        ok = 1'b0;
        hcyc = 0;
        @(negedge clk);
        if (toggle) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (bus.in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                hcyc = cyc;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout: got in_ready=0 for 20 cycles expected accept of byte %0h", b);
        end
    endtask

    task automatic send_hdr(input logic [7:0] b, input bit toggle);
        bit ok;
        int hc;
        send_byte(b, toggle, ok, hc);
    endtask

    task automatic send_data(input logic [7:0] b, input bit toggle);
        bit ok;
        int hc;
        wr_t e;
        send_byte(b, toggle, ok, hc);
        if (ok) begin
            e.addr = 12'h200 + widx[11:0];
            e.data = b;
            e.cyc  = hc;
            exp_q.push_back(e);
            widx++;
            sum = sum + b;
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        widx = 0;
        sum = 8'h00;
    endtask

    task automatic check_end(input string tag, input bit exp_done, input bit exp_err, input int exp_cnt);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        repeat (2) @(negedge clk);
        #1;
        chk({tag, "_done"},       32'(done), 32'(exp_done));
        chk({tag, "_error"},      32'(error), 32'(exp_err));
        chk({tag, "_busy"},       32'(busy), 32'h0);
        chk({tag, "_byte_count"}, 32'(byte_count), 32'(exp_cnt));
        chk({tag, "_in_ready"},   32'(bus.in_ready), 32'h0);
        chk({tag, "_pending"},    32'(exp_q.size()), 32'h0);
        bus.in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit exp_err;
        logic [15:0] l;
        l = 16'(v.len);
        exp_err = (v.len > 3584);
`ifdef LOADER_CHECKSUM_EN
        exp_err = exp_err || v.bad_csum;
`endif
        do_start();
        send_hdr(l[15:8], v.toggle);
        send_hdr(l[7:0], v.toggle);
        if (v.len <= 3584) begin
            for (int i = 0; i < v.len; i++) send_data(8'(v.seed + i * v.step), v.toggle);
`ifdef LOADER_CHECKSUM_EN
            send_hdr(v.bad_csum ? 8'(sum + 8'h01) : sum, v.toggle);
`endif
        end
        check_end($sformatf("vec%0d", idx), !exp_err, exp_err, (v.len > 3584) ? 0 : v.len);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3,    8'hA1, 8'h11, 1'b0, 1'b0};
        vecs[1] = '{2,    8'h11, 8'h11, 1'b1, 1'b0};
        vecs[2] = '{0,    8'h00, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{3585, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{3584, 8'h00, 8'h01, 1'b0, 1'b0};
        vecs[5] = '{2,    8'h10, 8'h10, 1'b0, 1'b0};
        vecs[6] = '{2,    8'h10, 8'h10, 1'b0, 1'b1};

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Restart mid-payload with a byte offered in the start cycle.
        do_start();
        send_hdr(8'h00, 1'b0);
        send_hdr(8'h05, 1'b0);
        send_data(8'h01, 1'b0);
        send_data(8'h02, 1'b0);
        @(negedge clk);
        start = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        #1;
        chk("restart_in_ready", 32'(bus.in_ready), 32'h0);
        @(negedge clk);
        start = 1'b0;
        bus.in_valid = 1'b0;
        widx = 0;
        sum = 8'h00;
        #1;
        chk("restart_byte_count", 32'(byte_count), 32'h0);
        chk("restart_busy", 32'(busy), 32'h1);
        send_hdr(8'h00, 1'b0);
        send_hdr(8'h01, 1'b0);
        send_data(8'h7F, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_hdr(sum, 1'b0);
`endif
        check_end("restart", 1'b1, 1'b0, 1);

        // Asynchronous reset while a write strobe is live.
        do_start();
        send_hdr(8'h00, 1'b0);
        send_hdr(8'h04, 1'b0);
        send_data(8'h31, 1'b0);
        send_data(8'h32, 1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("arst_pre_mem_we", 32'(bus.mem_we), 32'h1);
        chk("arst_pre_count", 32'(byte_count), 32'h2);
        rst_n = 1'b0;
        #1;
        check_reset_vals("arst");
        @(negedge clk);
        rst_n = 1'b1;
        chk("arst_pending", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
